hazard_scheduler: RTL and testbench

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/arm_pkg.sv | 15 +
 rtl/dest_match.sv | 17 +
 rtl/hazard_scheduler.sv | 95 +++++++++
 tb/tb_hazard_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared widths and the in-flight writer slot type for the hazard scheduler.
package arm_pkg;

    localparam int unsigned REG_IDX_W   = 4;
    localparam int unsigned STALL_CNT_W = 16;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r;
        logic [REG_IDX_W-1:0] dest;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/dest_match.sv
// Compares one in-flight writer against the decode-stage source operands.
module dest_match
    import arm_pkg::*;
(
    input  logic                 wb_en_i,
    input  logic [REG_IDX_W-1:0] dest_i,
    input  logic [REG_IDX_W-1:0] src1_i,
    input  logic [REG_IDX_W-1:0] src2_i,
    input  logic                 two_src_i,
    output logic                 match_o
);

    always_comb begin
        match_o = wb_en_i & ((dest_i == src1_i) | (two_src_i & (dest_i == src2_i)));
    end

endmodule

// File: rtl/hazard_scheduler.sv
// RAW hazard detection over the EX/MEM writer slots, with a saturating stall counter.
// Define HAZARD_SCHEDULER_FORWARDING_EN to stall only on load-use hazards.
module hazard_scheduler
    import arm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_IDX_W-1:0]   id_src1,
    input  logic [REG_IDX_W-1:0]   id_src2,
    input  logic                   id_two_src,
    input  logic                   id_wb_en,
    input  logic                   id_mem_r_en,
    input  logic [REG_IDX_W-1:0]   id_dest,
    input  logic                   branch_taken,
    output logic                   hazard,
    output logic                   pc_freeze,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CntMax = {STALL_CNT_W{1'b1}};

    slot_t                   ex_q, ex_d, mem_q, mem_d;
    logic [STALL_CNT_W-1:0]  stall_count_q, stall_count_d;
    logic                    ex_match, mem_match, hazard_cond;
    logic                    unused_slot;

    dest_match u_ex_match (
        .wb_en_i   (ex_q.wb_en),
        .dest_i    (ex_q.dest),
        .src1_i    (id_src1),
        .src2_i    (id_src2),
        .two_src_i (id_two_src),
        .match_o   (ex_match)
    );

    dest_match u_mem_match (
        .wb_en_i   (mem_q.wb_en),
        .dest_i    (mem_q.dest),
        .src1_i    (id_src1),
        .src2_i    (id_src2),
        .two_src_i (id_two_src),
        .match_o   (mem_match)
    );

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
    // Forwarding covers everything except a load whose data is not back yet.
    always_comb begin
        hazard_cond = ex_match & ex_q.mem_r;
        unused_slot = mem_match | mem_q.mem_r;
    end
`else
    always_comb begin
        hazard_cond = ex_match | mem_match;
        unused_slot = mem_q.mem_r;
    end
`endif

    // Outputs are forced low during reset even though the slots clear only at the edge.
    always_comb begin
        hazard        = id_valid & ~branch_taken & hazard_cond & ~rst;
        pc_freeze     = hazard;
        if_id_flush   = branch_taken & ~rst;
        id_ex_flush   = hazard | if_id_flush;
        stall_count   = rst ? '0 : stall_count_q;

        mem_d = ex_q;
        ex_d  = SLOT_BUBBLE;
        if (id_valid && !hazard && !branch_taken) begin
            ex_d.wb_en = id_wb_en;
            ex_d.mem_r = id_mem_r_en;
            ex_d.dest  = id_dest;
        end

        stall_count_d = stall_count_q;
        if (hazard && stall_count_q != CntMax) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= SLOT_BUBBLE;
            mem_q         <= SLOT_BUBBLE;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed table, corner sequences, random vs model.
module tb_hazard_scheduler;

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1, id_src2, id_dest;
    logic        id_two_src, id_wb_en, id_mem_r_en;
    logic        branch_taken;
    logic        hazard, pc_freeze, if_id_flush, id_ex_flush;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_wb_en     (id_wb_en),
        .id_mem_r_en  (id_mem_r_en),
        .id_dest      (id_dest),
        .branch_taken (branch_taken),
        .hazard       (hazard),
        .pc_freeze    (pc_freeze),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .stall_count  (stall_count)
    );

    typedef struct {
        logic       valid;
        logic [3:0] s1, s2;
        logic       two;
        logic       wb, mr;
        logic [3:0] dest;
        logic       br;
        logic       exp_haz;
    } vec_t;

    // An issued instruction as seen by later ones; wb=0 means nothing was issued.
    typedef struct packed {
        logic       wb;
        logic       mr;
        logic [3:0] dest;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    wr_t         hist[$];     // hist[0] issued last cycle, hist[1] the cycle before
    int unsigned model_cnt;

    function automatic vec_t mk(logic v, logic [3:0] s1, logic [3:0] s2, logic two, logic wb,
                                logic mr, logic [3:0] dest, logic br, logic eh);
        vec_t r;
        r.valid = v; r.s1 = s1; r.s2 = s2; r.two = two; r.wb = wb; r.mr = mr;
        r.dest = dest; r.br = br; r.exp_haz = eh;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
        id_wb_en = v.wb; id_mem_r_en = v.mr; id_dest = v.dest; branch_taken = v.br;
    endtask

    function automatic logic reads(wr_t w);
        return w.wb && (w.dest == id_src1 || (id_two_src && w.dest == id_src2));
    endfunction

    function automatic logic model_hazard();
        if (rst || !id_valid || branch_taken) return 1'b0;
        if (FWD) return reads(hist[0]) && hist[0].mr;
        return reads(hist[0]) || reads(hist[1]);
    endfunction

    // One clock: compare at negedge against the model (and an optional fixed value), then advance.
    task automatic cycle(input string name, input int tbl_exp);
        logic h;
        logic br;
        wr_t  nw;
        h  = model_hazard();
        br = branch_taken && !rst;
        @(negedge clk);
        if (tbl_exp >= 0) check({name, ".tbl_hazard"}, {15'd0, hazard}, tbl_exp[15:0]);
        check({name, ".hazard"}, {15'd0, hazard}, {15'd0, h});
        check({name, ".pc_freeze"}, {15'd0, pc_freeze}, {15'd0, h});
        check({name, ".if_id_flush"}, {15'd0, if_id_flush}, {15'd0, br});
        check({name, ".id_ex_flush"}, {15'd0, id_ex_flush}, {15'd0, h | br});
        check({name, ".stall_count"}, stall_count, rst ? 16'd0 : model_cnt[15:0]);
        @(posedge clk);
        if (rst) begin
            hist      = '{'0, '0};
            model_cnt = 0;
        end else begin
            if (h && model_cnt < 32'hFFFF) model_cnt++;
            nw = '0;
            if (id_valid && !h && !branch_taken) nw = '{id_wb_en, id_mem_r_en, id_dest};
            hist.push_front(nw);
            void'(hist.pop_back());
        end
        #1;
    endtask

    vec_t tbl[18];
    vec_t idle, ldr4, use4, add1, use1;
    int   stalls;

    initial begin
        hist      = '{'0, '0};
        model_cnt = 0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ldr4 = mk(1, 0, 0, 0, 1, 1, 4, 0, 0);
        use4 = mk(1, 4, 4, 1, 1, 0, 5, 0, 1);
        add1 = mk(1, 2, 3, 1, 1, 0, 1, 0, 0);
        use1 = mk(1, 1, 3, 1, 1, 0, 2, 0, 0);

        tbl[0]  = mk(1, 2, 3, 1, 1, 0, 1, 0, 0);       // ADD R1,R2,R3
        tbl[1]  = mk(1, 1, 3, 1, 1, 0, 2, 0, !FWD);    // SUB R2,R1,R3
        tbl[2]  = mk(1, 1, 3, 1, 1, 0, 2, 0, !FWD);
        tbl[3]  = mk(1, 1, 3, 1, 1, 0, 2, 0, 0);
        tbl[4]  = mk(1, 5, 0, 0, 1, 1, 4, 0, 0);       // LDR R4,[R5]
        tbl[5]  = mk(1, 4, 4, 1, 1, 0, 5, 0, 1);       // ADD R5,R4,R4
        tbl[6]  = mk(1, 4, 4, 1, 1, 0, 5, 0, !FWD);
        tbl[7]  = mk(1, 4, 4, 1, 1, 0, 5, 0, 0);
        tbl[8]  = mk(1, 6, 0, 0, 1, 0, 1, 0, 0);       // ADD R1,R6
        tbl[9]  = mk(1, 1, 1, 1, 1, 0, 6, 0, !FWD);    // ADD R6,R1,R1
        tbl[10] = idle;
        tbl[11] = mk(1, 10, 0, 0, 1, 0, 9, 0, 0);      // writes R9
        tbl[12] = mk(1, 11, 9, 0, 1, 0, 12, 0, 0);     // src2 matches but is not an operand
        tbl[13] = mk(1, 11, 9, 1, 1, 0, 12, 0, !FWD);
        tbl[14] = mk(1, 0, 0, 0, 1, 1, 13, 0, 0);      // LDR R13
        tbl[15] = mk(1, 13, 0, 0, 1, 0, 14, 1, 0);     // branch taken while RAW pending
        tbl[16] = mk(1, 13, 0, 0, 1, 0, 14, 0, !FWD);  // EX was bubbled by the branch
        tbl[17] = idle;

        // Reset with live-looking inputs: every output must stay low.
        rst = 1'b1;
        drive(mk(1, 1, 1, 1, 1, 1, 1, 1, 0));
        #1;
        cycle("reset0", 0);
        cycle("reset1", 0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            cycle($sformatf("tbl%0d", i), int'(tbl[i].exp_haz));
        end
        check("tbl.count_end", stall_count, FWD ? 16'd1 : 16'd7);

        // Saturation: preload near the top, then collect three stall cycles.
        drive(idle);
        force dut.stall_count_q = 16'hFFFE;
        model_cnt = 32'hFFFE;
        cycle("sat_preload", 0);
        release dut.stall_count_q;
        stalls = 0;
        for (int i = 0; i < 20 && stalls < 3; i++) begin
            drive((i % 2 == 0) ? ldr4 : use4);
            if (model_hazard()) stalls++;
            cycle($sformatf("sat%0d", i), -1);
        end
        check("sat.stalls_seen", stalls[15:0], 16'd3);
        drive(idle);
        cycle("sat_idle", 0);
        check("sat.final", stall_count, 16'hFFFF);

        // Reset mid-stall aborts it and leaves the slots empty.
        drive(ldr4);
        cycle("rs_prod", 0);
        drive(use4);
        cycle("rs_stall", 1);
        rst = 1'b1;
        cycle("rs_reset", 0);
        rst = 1'b0;
        cycle("rs_after", 0);
        check("rs.count", stall_count, 16'd0);

        // Non-load producer into a dependent: stalls only without forwarding.
        drive(add1);
        cycle("raw_prod", 0);
        drive(use1);
        cycle("raw_use", int'(!FWD));

        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 39) == 0);
            id_valid     = ($urandom_range(0, 7) != 0);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_two_src   = 1'($urandom);
            id_wb_en     = ($urandom_range(0, 3) != 0);
            id_mem_r_en  = 1'($urandom);
            id_dest      = 4'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 7) == 0);
            cycle($sformatf("rand%0d", i), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
